// File: rtl/intc_if.sv
// intc_if: bus between the CPU-side uib master and the intc register slave.
// Ports: dat_i (write data), dat_o (read data), addr (slave-local byte
// address), mode (access size, 3'b010 = word), wen (1 = write), req (held
// by the master until ready), ready (one-cycle completion pulse).
interface intc_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 28
);
    logic [XLEN-1:0]   dat_i;
    logic [XLEN-1:0]   dat_o;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        mode;
    logic              wen;
    logic              req;
    logic              ready;

    modport master (output dat_i, addr, mode, wen, req, input dat_o, ready);
    modport slave  (input dat_i, addr, mode, wen, req, output dat_o, ready);
endinterface

// File: rtl/intc.sv
// intc: interrupt controller latching NSRC sources as pending and raising intr to the CPU.
// Ports: clk, rst (async, active-low), src (raw async interrupt lines),
// intr (registered request to the CPU), bus (intc_if slave: PENDING, ENABLE,
// CLAIM, EDGE and SWSET registers decoded on addr[4:2]).
module intc #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 28,
    parameter int NSRC   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src,
    output logic            intr,
    intc_if.slave           bus
);
    typedef enum logic {IDLE, RESP} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] s1_q, s2_q, s3_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] en_q, en_d;
    logic [NSRC-1:0] edge_q, edge_d;
    logic            busy_q, busy_d;
    logic [4:0]      insvc_q, insvc_d;
    logic            intr_q, intr_d;
    logic [XLEN-1:0] dat_o_q, dat_o_d;

    logic [NSRC-1:0] active, set, clr, svc;
    logic [XLEN-1:0] rdata;
    logic [4:0]      id;
    logic [2:0]      sel;
    logic            access, wr_ok, claim, complete;
    logic            unused_bits;

    assign unused_bits = ^{bus.addr[ADDR_W-1:5], bus.addr[1:0], bus.dat_i};

    always_comb begin
        active   = pend_q & en_q;
        id       = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (active[i]) id = 5'(i);
        sel      = bus.addr[4:2];
        access   = state_q == IDLE && bus.req;
        wr_ok    = access && bus.wen && bus.mode == 3'b010;
        claim    = access && !bus.wen && sel == 3'd2 && !busy_q && |active;
        complete = wr_ok && sel == 3'd2 && busy_q && bus.dat_i[4:0] == insvc_q + 5'd1;
        state_d  = access ? RESP : IDLE;
        en_d     = wr_ok && sel == 3'd1 ? bus.dat_i[NSRC-1:0] : en_q;
        edge_d   = wr_ok && sel == 3'd3 ? bus.dat_i[NSRC-1:0] : edge_q;
        busy_d   = claim ? 1'b1 : complete ? 1'b0 : busy_q;
        insvc_d  = claim ? id : insvc_q;
        // In-service uses next-state so a level source being claimed this cycle is not re-set over its own clear
        svc      = busy_d ? NSRC'(1) << insvc_d : '0;
        set      = (s2_q & ~s3_q & edge_q)
                 | (s2_q & ~edge_q & ~svc)
                 | (wr_ok && sel == 3'd4 ? bus.dat_i[NSRC-1:0] : '0);
        clr      = claim ? NSRC'(1) << id : '0;
        pend_d   = (pend_q & ~clr) | set;
        intr_d   = |active && !busy_q;
        rdata    = sel == 3'd0 ? XLEN'(pend_q)
                 : sel == 3'd1 ? XLEN'(en_q)
                 : sel == 3'd2 ? (claim ? XLEN'(id + 5'd1) : '0)
                 : sel == 3'd3 ? XLEN'(edge_q)
                 : '0;
        dat_o_d  = !access ? dat_o_q : bus.wen ? '0 : rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            s1_q    <= '0;
            s2_q    <= '0;
            s3_q    <= '0;
            pend_q  <= '0;
            en_q    <= '0;
            edge_q  <= '0;
            busy_q  <= 1'b0;
            insvc_q <= '0;
            intr_q  <= 1'b0;
            dat_o_q <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= src;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            pend_q  <= pend_d;
            en_q    <= en_d;
            edge_q  <= edge_d;
            busy_q  <= busy_d;
            insvc_q <= insvc_d;
            intr_q  <= intr_d;
            dat_o_q <= dat_o_d;
        end
    end

    assign intr      = intr_q;
    assign bus.ready = state_q == RESP;
    assign bus.dat_o = dat_o_q;
endmodule

// File: tb/tb_intc.sv
// tb_intc: directed and randomized checks of intc against a transaction-level model.
module tb_intc;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] src;
    logic       intr;
    int         total = 0;
    int         bad = 0;

    logic [7:0] m_pend, m_en, m_edg, m_src;
    logic       m_busy;
    logic [4:0] m_svc;

    intc_if #(.XLEN(32), .ADDR_W(28)) bif ();

    intc #(.XLEN(32), .ADDR_W(28), .NSRC(8)) dut (
        .clk (clk),
        .rst (rst),
        .src (src),
        .intr(intr),
        .bus (bif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic bus(input logic w, input logic [2:0] sel, input logic [31:0] d,
                       input logic [2:0] m, output logic [31:0] r);
        logic [27:0] a;
        int n;
        a = 28'($urandom);
        a[4:2] = sel;
        bif.addr = a;
        bif.wen = w;
        bif.dat_i = d;
        bif.mode = m;
        bif.req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bif.ready !== 1'b1 && n < 8);
        chk("ready_latency", n, 32'd1);
        bif.req = 1'b0;
        r = bif.dat_o;
        if (w) chk("write_dat_o", r, 32'd0);
        @(negedge clk);
        chk("ready_pulse", 32'(bif.ready), 32'd0);
    endtask

    task automatic rd(input logic [2:0] sel, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        bus(1'b0, sel, $urandom, 3'($urandom), r);
        chk(tag, r, exp);
    endtask

    task automatic wr(input logic [2:0] sel, input logic [31:0] d);
        logic [31:0] r;
        bus(1'b1, sel, d, 3'b010, r);
    endtask

    function automatic logic [7:0] svc_mask();
        return m_busy ? 8'd1 << m_svc : 8'd0;
    endfunction

    task automatic m_refresh();
        m_pend = m_pend | (m_src & ~m_edg & ~svc_mask());
    endtask

    task automatic m_claim(output logic [31:0] e);
        logic [7:0] a;
        a = m_pend & m_en;
        e = 32'd0;
        if (!m_busy && a != 8'd0) begin
            for (int i = 7; i >= 0; i--)
                if (a[i]) m_svc = 5'(i);
            m_pend[m_svc] = 1'b0;
            m_busy = 1'b1;
            e = 32'(m_svc) + 32'd1;
        end
    endtask

    initial begin
        logic [31:0] r, d, e;
        logic [7:0]  ns;
        logic [2:0]  s, m;
        int          n, op;
        rst = 1'b0;
        src = 8'h00;
        bif.req = 1'b0;
        bif.wen = 1'b0;
        bif.addr = '0;
        bif.dat_i = '0;
        bif.mode = 3'b010;
        idle(2);
        chk("rst_intr", 32'(intr), 32'd0);
        chk("rst_ready", 32'(bif.ready), 32'd0);
        chk("rst_dat_o", bif.dat_o, 32'd0);
        rst = 1'b1;
        idle(1);
        rd(3'd0, 32'd0, "rst_pending");
        rd(3'd1, 32'd0, "rst_enable");
        rd(3'd3, 32'd0, "rst_edge");

        wr(3'd1, 32'h01);
        wr(3'd3, 32'h01);
        src = 8'h01;
        n = 0;
        do begin
            @(negedge clk);
            src = 8'h00;
            n++;
        end while (intr !== 1'b1 && n < 8);
        chk("t1_intr", 32'(intr), 32'd1);
        chk("t1_intr_within_4", 32'(n <= 4), 32'd1);
        rd(3'd0, 32'h01, "t1_pending");
        rd(3'd2, 32'd1, "t1_claim");
        chk("t1_intr_drop", 32'(intr), 32'd0);
        rd(3'd0, 32'd0, "t1_pending_clr");
        wr(3'd2, 32'd1);

        wr(3'd1, 32'h09);
        wr(3'd3, 32'h09);
        src = 8'h09;
        idle(5);
        rd(3'd2, 32'd1, "t2_claim1");
        rd(3'd2, 32'd0, "t2_claim_busy");
        wr(3'd2, 32'd1);
        idle(3);
        chk("t2_intr_again", 32'(intr), 32'd1);
        rd(3'd2, 32'd4, "t2_claim4");
        wr(3'd2, 32'd4);
        src = 8'h00;
        idle(3);

        wr(3'd3, 32'h00);
        wr(3'd1, 32'h02);
        src = 8'h02;
        idle(5);
        rd(3'd2, 32'd2, "t3_claim");
        idle(3);
        rd(3'd0, 32'h00, "t3_pend_insvc");
        wr(3'd2, 32'd2);
        idle(3);
        rd(3'd0, 32'h02, "t3_pend_again");
        src = 8'h00;
        idle(5);
        rd(3'd2, 32'd2, "t3_claim2");
        rd(3'd0, 32'h00, "t3_pend_zero");
        wr(3'd2, 32'd2);

        wr(3'd4, 32'h80);
        wr(3'd1, 32'h80);
        idle(3);
        chk("t4_intr", 32'(intr), 32'd1);
        rd(3'd2, 32'd8, "t4_claim");
        wr(3'd2, 32'd3);
        idle(3);
        chk("t4_intr_busy", 32'(intr), 32'd0);
        rd(3'd2, 32'd0, "t4_claim_busy");
        wr(3'd2, 32'd8);
        idle(3);
        chk("t4_intr_done", 32'(intr), 32'd0);

        bif.addr = '0;
        bif.wen = 1'b0;
        bif.mode = 3'b010;
        bif.req = 1'b1;
        @(negedge clk);
        chk("t5_ready1", 32'(bif.ready), 32'd1);
        @(negedge clk);
        chk("t5_gap", 32'(bif.ready), 32'd0);
        @(negedge clk);
        chk("t5_ready2", 32'(bif.ready), 32'd1);
        bif.req = 1'b0;
        @(negedge clk);
        chk("t5_idle", 32'(bif.ready), 32'd0);
        bus(1'b1, 3'd1, 32'hff, 3'b000, r);
        rd(3'd1, 32'h80, "t5_enable_kept");

        wr(3'd4, 32'hff);
        wr(3'd1, 32'hff);
        idle(3);
        chk("t6_intr", 32'(intr), 32'd1);
        bif.addr = '0;
        bif.wen = 1'b0;
        bif.req = 1'b1;
        @(posedge clk);
        #2;
        chk("t6_in_resp", 32'(bif.ready), 32'd1);
        chk("t6_dat_o_before", bif.dat_o, 32'hff);
        rst = 1'b0;
        #1;
        chk("t6_ready", 32'(bif.ready), 32'd0);
        chk("t6_intr0", 32'(intr), 32'd0);
        chk("t6_dat_o", bif.dat_o, 32'd0);
        bif.req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        rd(3'd0, 32'd0, "t6_pending");
        rd(3'd1, 32'd0, "t6_enable");
        rd(3'd2, 32'd0, "t6_claim");

        m_pend = 8'h00;
        m_en = 8'h00;
        m_edg = 8'h00;
        m_src = 8'h00;
        m_busy = 1'b0;
        m_svc = 5'd0;
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: begin
                    ns = 8'($urandom);
                    m_pend = m_pend | (ns & ~m_src & m_edg);
                    m_src = ns;
                    src = ns;
                    idle(5);
                end
                1: begin
                    d = $urandom;
                    wr(3'd1, d);
                    m_en = d[7:0];
                end
                2: begin
                    d = $urandom;
                    wr(3'd3, d);
                    m_edg = d[7:0];
                end
                3: begin
                    d = $urandom & $urandom;
                    wr(3'd4, d);
                    m_pend = m_pend | d[7:0];
                end
                4: begin
                    m_claim(e);
                    rd(3'd2, e, "rand_claim");
                end
                5: begin
                    d = ($urandom_range(0, 1) == 1) ? 32'(m_svc) + 32'd1 : 32'($urandom_range(0, 31));
                    d = d | ($urandom & 32'hffffffe0);
                    wr(3'd2, d);
                    if (m_busy && d[4:0] == m_svc + 5'd1) m_busy = 1'b0;
                end
                6: begin
                    s = 3'($urandom);
                    if (s == 3'd2) s = 3'd0;
                    e = s == 3'd0 ? 32'(m_pend) : s == 3'd1 ? 32'(m_en) : s == 3'd3 ? 32'(m_edg) : 32'd0;
                    rd(s, e, "rand_read");
                end
                default: begin
                    m = 3'($urandom);
                    if (m == 3'b010) m = 3'b110;
                    bus(1'b1, 3'($urandom), $urandom, m, r);
                end
            endcase
            idle(3);
            m_refresh();
            chk("rand_intr", 32'(intr), 32'((|(m_pend & m_en)) & ~m_busy));
        end
        rd(3'd0, 32'(m_pend), "final_pending");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/intc.md
Name: intc

Overview:
- Interrupt controller; uib slave that sits directly upstream of cpu_0's intr input.
- Collects NSRC interrupt lines (timer, uart, spare) and latches them as pending.
- Applies per-source enable and edge/level mode.
- Drives a single intr to the CPU; the CPU claims and completes interrupts through memory-mapped registers.

Parameters:
XLEN, 32, data width of the bus
ADDR_W, 28, slave-local address width (XLEN - SLAVE_WIDTH)
NSRC, 8, number of interrupt sources (1..31)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
src  input  NSRC  raw interrupt lines, asynchronous, active-high
intr  output  1  interrupt request to cpu
dat_i  input  XLEN  write data from bus
dat_o  output  XLEN  read data to bus
addr  input  ADDR_W  slave-local byte address
mode  input  3  access size (3'b010 = word)
wen  input  1  1 = write, 0 = read
req  input  1  request, held by bus until ready
ready  output  1  one-cycle completion pulse

Behaviour:
- Reset (rst low, async): all registers 0; FSM IDLE; intr=0, ready=0, dat_o=0; sync flops 0.
- Source sync: each src bit goes through a 2-flop synchronizer (s2), then a previous-value flop (s3). Edge = s2 & ~s3.
- Register map, decoded on addr[4:2]; addr[1:0] and upper bits ignored:
  - 0 PENDING: RO.
  - 1 ENABLE: RW.
  - 2 CLAIM: R = claim, W = complete.
  - 3 EDGE: RW; 1 = edge mode, 0 = level mode.
  - 4 SWSET: WO, write-1-to-set pending.
  - 5-7: reads return 0, writes ignored.
- Register widths: only bits [NSRC-1:0] are stored; unused bits read 0.
- Pending set per cycle:
  - Edge mode: on edge.
  - Level mode: while s2=1 and source not in service.
  - Any source: on an SWSET bit written as 1.
- Pending clear: only by a claim of that source. If set and clear hit the same bit in the same cycle, set wins.
- Active = pending & enable. intr = |active & ~busy, registered (1-cycle delay). busy = a claim is outstanding; no nesting.
- Claim read:
  - Returns id+1 of the lowest-index active source, or 0 if none.
  - If nonzero: clears that pending bit, records the id in insvc, sets busy.
  - If busy is already set: returns 0 and changes nothing.
- Complete write:
  - If busy and dat_i[4:0] == insvc+1: clear busy.
  - Otherwise: ignored.
- Bus FSM, states IDLE and RESP:
  - IDLE & req: perform the access this cycle, load dat_o, go to RESP.
  - RESP: ready=1 for exactly one cycle, return to IDLE.
  - Latency: ready in the cycle after req is seen. Back-to-back requests get one idle cycle between readies.
  - req dropping while in RESP: no effect, response still completes.
- Mode handling:
  - Only mode 3'b010 writes take effect; other-mode writes are acked but do not modify state.
  - Reads ignore mode and return the full word.
- dat_o holds its last read value between accesses; after a write it is 0.
- Reset mid-transaction: FSM returns to IDLE, no ready is emitted, pending and busy state are lost.
- ENABLE cleared while pending: pending stays, intr drops on the next cycle.

Test Plan:
1. Reset, then ENABLE=0x01, EDGE=0x01; pulse src[0] for 1 cycle -> PENDING=0x01 and intr=1 within 4 cycles; CLAIM read returns 1; intr=0 the next cycle; PENDING=0.
2. src[0] and src[3] rise together, ENABLE=0x09 -> CLAIM returns 1; a second CLAIM before complete returns 0; write 1 to CLAIM -> intr reasserts; CLAIM returns 4.
3. Level mode: src[1] held high, ENABLE=0x02 -> CLAIM returns 2; PENDING does not reset while in service; after complete, PENDING[1]=1 again; drop src[1] and claim -> PENDING=0.
4. SWSET write 0x80, ENABLE=0x80 -> intr=1, CLAIM returns 8. A wrong complete value of 3 leaves busy set and intr=0.
5. Bus timing: req held 3 cycles on a read -> ready high exactly 1 cycle, in the cycle after req; a write with mode=3'b000 to ENABLE is acked and ENABLE is unchanged.
6. Assert rst low while in RESP with PENDING=0xFF -> ready=0, intr=0, all registers 0 immediately, before the next clk edge.
